character_renderer: RTL and testbench

//   Consumer of the character FSM's 4-bit position code (CurrState). Tracks the

---
 rtl/character_renderer.sv | 170 +++++++++++++++++
 tb/tb_character_renderer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/character_renderer.sv
// character_renderer
// Tracks which lane (0..3) the character occupies, as reported by the
// character FSM's position code, and keeps its sprite on the VGA frame buffer
// up to date. A lane change produces an erase pass over the old sprite in the
// background colour followed by a draw pass at the new lane, one pixel per
// clock, in raster order (x fastest). Out of reset the sprite is drawn once at
// lane 0 with no erase, since nothing is on screen yet.

module character_renderer #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         LANE_X0     = 12,
    parameter int         LANE_PITCH  = 40,
    parameter int         SPRITE_Y    = 100,
    parameter logic [2:0] CHAR_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] CurrState,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    // Counter widths; a 1-pixel dimension still needs a 1-bit counter.
    localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     r_target;
    logic [1:0]     r_drawn;
    logic [1:0]     r_drawPos;
    logic [CXW-1:0] r_cx;
    logic [CYW-1:0] r_cy;
    logic [7:0]     r_x;
    logic [6:0]     r_y;
    logic [2:0]     r_colour;
    logic           r_plot;
    logic           r_busy;

    logic           w_cxLast;
    logic           w_cyLast;
    logic           w_passLast;
    logic           w_laneCode;
    logic [1:0]     w_lane;
    logic [8:0]     w_xSum;
    logic [8:0]     w_ySum;

    assign w_cxLast   = (r_cx == CXW'(SPRITE_W - 1));
    assign w_cyLast   = (r_cy == CYW'(SPRITE_H - 1));
    assign w_passLast = w_cxLast && w_cyLast;
    assign w_laneCode = (CurrState <= 4'd3);

    // Erase works on the sprite currently on screen; draw works on the
    // lane snapshotted when the erase finished (or lane 0 out of reset).
    assign w_lane = (r_state == S_ERASE) ? r_drawn : r_drawPos;

    // Pixel address in 9 bits; legal parameters keep the result in range
    // so truncation to the VGA port widths never wraps.
    assign w_xSum = 9'(LANE_X0) + 9'(w_lane) * 9'(LANE_PITCH) + 9'(r_cx);
    assign w_ySum = 9'(SPRITE_Y) + 9'(r_cy);

    // Lane request: only stable lane codes update it, so the in-between
    // transition codes never trigger a redraw.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_target <= 2'd0;
        end else if (w_laneCode) begin
            r_target <= CurrState[1:0];
        end
    end

    // Raster counters: cleared while idle, stepped every cycle of a pass.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (r_state == S_IDLE) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_cxLast) begin
            r_cx <= '0;
            r_cy <= w_cyLast ? '0 : r_cy + 1'b1;
        end else begin
            r_cx <= r_cx + 1'b1;
        end
    end

    // Pass sequencing plus the on-screen / pending lane bookkeeping.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_DRAW;
            r_drawn   <= 2'd0;
            r_drawPos <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_target != r_drawn) begin
                        r_state <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (w_passLast) begin
                        r_drawPos <= r_target;
                        r_state   <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_passLast) begin
                        r_drawn <= r_drawPos;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered VGA write port and busy flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_plot <= 1'b0;
                    r_busy <= (r_target != r_drawn);
                end
                S_ERASE: begin
                    r_x      <= w_xSum[7:0];
                    r_y      <= w_ySum[6:0];
                    r_colour <= BG_COLOUR;
                    r_plot   <= 1'b1;
                    r_busy   <= 1'b1;
                end
                S_DRAW: begin
                    r_x      <= w_xSum[7:0];
                    r_y      <= w_ySum[6:0];
                    r_colour <= CHAR_COLOUR;
                    r_plot   <= 1'b1;
                    r_busy   <= 1'b1;
                end
                default: begin
                    r_plot <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;

endmodule

// File: tb/tb_character_renderer.sv
// tb_character_renderer
// Captures every plotted pixel and compares the stream against pixel passes
// built from the lane geometry, tracking which lane should be on screen.

module tb_character_renderer;

   localparam int NPIX = 256;

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] CurrState = 4'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;

   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   int   mDrawn = 0;
   pix_t capQ[$];
   int   capT[$];
   pix_t expQ[$];

   character_renderer dut (
      .Clock(Clock), .Reset(Reset), .CurrState(CurrState),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
   );

   // free-running clock
   always #5 Clock = ~Clock;

   // record every plotted pixel with the cycle it appeared in
   always @(negedge Clock) begin
      cycle++;
      if (plot === 1'b1) begin
         capQ.push_back('{px: x, py: y, pc: colour});
         capT.push_back(cycle);
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         #2;
      end
   endtask

   task automatic clearCap();
      capQ.delete();
      capT.delete();
      expQ.delete();
   endtask

   // one full sprite pass at a lane, raster order with x fastest
   function automatic void addPass(input int lane, input logic [2:0] col);
      for (int i = 0; i < NPIX; i++)
         expQ.push_back('{px: 8'(12 + lane * 40 + i % 16), py: 7'(100 + i / 16), pc: col});
   endfunction

   // a lane change from the model's on-screen lane: erase then draw
   function automatic void addMove(input int lane);
      addPass(mDrawn, 3'b000);
      addPass(lane, 3'b010);
      mDrawn = lane;
   endfunction

   function automatic int firstDiff();
      int n;
      n = (capQ.size() < expQ.size()) ? capQ.size() : expQ.size();
      for (int i = 0; i < n; i++)
         if (capQ[i] !== expQ[i]) return i;
      if (capQ.size() != expQ.size()) return n;
      return -1;
   endfunction

   // first position inside a 256-pixel pass that is not back-to-back
   function automatic int firstGap();
      for (int i = 1; i < capT.size(); i++)
         if ((i % NPIX) != 0 && capT[i] != capT[i-1] + 1) return i;
      return -1;
   endfunction

   task automatic waitIdle(input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 3000) begin
         cyc();
         n++;
         quiet = (busy === 1'b0 && plot === 1'b0) ? quiet + 1 : 0;
      end
      total++;
      if (quiet < 4) begin
         bad++;
         $display("[TB] FAIL %s idle timeout: busy=%b plot=%b required busy=0 plot=0", name, busy, plot);
      end
   endtask

   task automatic waitCount(input string name, input int cnt);
      int n = 0;
      while (capQ.size() < cnt && n < 3000) begin
         cyc();
         n++;
      end
      total++;
      if (capQ.size() != cnt) begin
         bad++;
         $display("[TB] FAIL %s pixel wait: got %0d pixels required %0d", name, capQ.size(), cnt);
      end
   endtask

   task automatic applyStimulus(input int code, input int cycles);
      CurrState = 4'(code);
      cyc(cycles);
   endtask

   task automatic test_reset();
      int d;
      Reset = 1'b0;
      CurrState = 4'd0;
      cyc(3);
      total++;
      if (plot !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset flags: plot=%b busy=%b required plot=0 busy=1", plot, busy);
      end
      total++;
      if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
         bad++;
         $display("[TB] FAIL reset pixel: x=%0d y=%0d c=%0d required 0 0 0", x, y, colour);
      end
      clearCap();
      Reset = 1'b1;
      mDrawn = 0;
      addPass(0, 3'b010);
      waitIdle("initial draw");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL initial draw stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
      d = firstGap();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL initial draw gap at pixel %0d, got gap required none", d);
      end
   endtask

   task automatic test_transitions();
      int d;
      int c0;
      clearCap();
      applyStimulus(4, 10);
      applyStimulus(12, 10);
      total++;
      if (capQ.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL transition codes: got %0d pixels busy=%b required 0 pixels busy=0", capQ.size(), busy);
      end
      c0 = cycle;
      CurrState = 4'd1;
      addMove(1);
      waitIdle("move 0->1");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL move 0->1 stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
      total++;
      if (capT.size() == 0 || capT[0] - c0 < 2 || capT[0] - c0 > 3) begin
         bad++;
         $display("[TB] FAIL move latency: got %0d cycles required 2..3", (capT.size() > 0) ? capT[0] - c0 : -1);
      end
      d = firstGap();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL move 0->1 gap at pixel %0d, got gap required none", d);
      end
      clearCap();
      applyStimulus(12, 10);
      total++;
      if (capQ.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL unused code: got %0d pixels busy=%b required 0 pixels busy=0", capQ.size(), busy);
      end
   endtask

   task automatic test_erase_change();
      int d;
      clearCap();
      CurrState = 4'd2;
      waitCount("erase absorb", 100);
      applyStimulus(5, 1);
      CurrState = 4'd3;
      addPass(1, 3'b000);
      addPass(3, 3'b010);
      mDrawn = 3;
      waitIdle("erase absorb");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL erase absorb stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
      clearCap();
      CurrState = 4'd0;
      waitCount("erase return", 30);
      CurrState = 4'd3;
      addPass(3, 3'b000);
      addPass(3, 3'b010);
      waitIdle("erase return");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL erase return stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
   endtask

   task automatic test_draw_change();
      int d;
      CurrState = 4'd1;
      waitIdle("to lane 1");
      mDrawn = 1;
      clearCap();
      CurrState = 4'd2;
      waitCount("draw change", NPIX + 50);
      CurrState = 4'd3;
      addMove(2);
      addMove(3);
      waitIdle("draw change");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL draw change stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
      total++;
      if (capT.size() < 513 || capT[512] - capT[511] != 2) begin
         bad++;
         $display("[TB] FAIL draw-erase idle gap: got %0d required 2", (capT.size() >= 513) ? capT[512] - capT[511] : -1);
      end
   endtask

   task automatic test_reset_mid();
      int d;
      clearCap();
      CurrState = 4'd2;
      waitCount("reset mid", NPIX + 40);
      Reset = 1'b0;
      CurrState = 4'd0;
      #1;
      total++;
      if (plot !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid reset: plot=%b busy=%b required plot=0 busy=1", plot, busy);
      end
      cyc(2);
      clearCap();
      Reset = 1'b1;
      mDrawn = 0;
      addPass(0, 3'b010);
      waitIdle("reset restart");
      d = firstDiff();
      total++;
      if (d != -1) begin
         bad++;
         $display("[TB] FAIL reset restart stream: diff at %0d, got %0d pixels required %0d", d, capQ.size(), expQ.size());
      end
   endtask

   task automatic test_random();
      int d, lane, lane2, mode, k;
      for (int it = 0; it < 8; it++) begin
         clearCap();
         mode = $urandom_range(0, 2);
         lane = (mDrawn + 1 + $urandom_range(0, 2)) % 4;
         lane2 = $urandom_range(0, 3);
         k = $urandom_range(1, 250);
         applyStimulus($urandom_range(4, 15), $urandom_range(1, 5));
         CurrState = 4'(lane);
         if (mode == 0) begin
            addMove(lane);
         end else if (mode == 1) begin
            waitCount("random erase", k);
            CurrState = 4'(lane2);
            addMove(lane2);
         end else begin
            waitCount("random draw", NPIX + k);
            CurrState = 4'(lane2);
            addMove(lane);
            if (lane2 != lane) addMove(lane2);
         end
         waitIdle("random");
         d = firstDiff();
         total++;
         if (d != -1) begin
            bad++;
            $display("[TB] FAIL random it%0d mode%0d stream: diff at %0d, got %0d pixels required %0d", it, mode, d, capQ.size(), expQ.size());
         end
         d = firstGap();
         total++;
         if (d != -1) begin
            bad++;
            $display("[TB] FAIL random it%0d gap at pixel %0d, got gap required none", it, d);
         end
      end
   endtask

   // run every scenario in order, then report
   initial begin
      test_reset();
      test_transitions();
      test_erase_change();
      test_draw_change();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
